// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer and anything that talks to the
// team's combinational 8-bit ALU: opcode encodings and the issuer FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_MOD = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset (count -> 0)
//   inc   - add one this cycle (ignored once the counter is full)
//   clr   - synchronous clear; an increment in the same cycle still counts
//   count - current count
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Sequential initiator for the combinational 8-bit ALU. Accepts tagged commands,
// holds the operands registered on the ALU inputs for one full cycle, captures the
// result/error and returns it with the tag on a valid/ready response channel.
// Ports:
//   clk, rst                      - clock and synchronous active-high reset
//   cmd_valid/cmd_ready           - command handshake
//   cmd_a/cmd_b/cmd_op/cmd_tag    - command payload
//   alu_a/alu_b/alu_op            - registered operands to the ALU
//   alu_result/alu_error          - combinational ALU outputs
//   rsp_valid/rsp_ready           - response handshake
//   rsp_result/rsp_error/rsp_tag  - response payload
//   busy                          - FSM not idle
//   err_count/err_clr             - saturating error-response counter and its clear
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_result,
  input  logic             alu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_error,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  state_e           state_q, state_d;
  logic [7:0]       alu_a_q, alu_b_q;
  logic [2:0]       alu_op_q;
  logic [TAG_W-1:0] tag_q;
  logic [7:0]       rsp_result_q;
  logic             rsp_error_q;
  logic [TAG_W-1:0] rsp_tag_q;

  logic cmd_accept;
  logic rsp_fire;

  // A new command may enter from IDLE, or from RESP in the same cycle the
  // pending response is consumed (back-to-back issue).
  always_comb begin
    cmd_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE:    cmd_ready = 1'b1;
        RESP:    cmd_ready = rsp_ready;
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  assign cmd_accept = cmd_valid & cmd_ready;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_fire   = rsp_valid & rsp_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_accept) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = cmd_accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q <= state_d;
      // Operands move only on acceptance so the ALU inputs never glitch.
      if (cmd_accept) begin
        alu_a_q  <= cmd_a;
        alu_b_q  <= cmd_b;
        alu_op_q <= cmd_op;
        tag_q    <= cmd_tag;
      end
      // The ALU has seen stable inputs for the whole ISSUE cycle.
      if (state_q == ISSUE) begin
        rsp_result_q <= alu_result;
        rsp_error_q  <= alu_error;
        rsp_tag_q    <= tag_q;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rsp_fire & rsp_error_q),
    .clr   (err_clr),
    .count (err_count)
  );

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_tag    = rsp_tag_q;
  assign busy       = (state_q != IDLE);

endmodule
